// File: rtl/softmax_pkg.sv
// +----------------------------------------------------------------------+
// | softmax_pkg                                                          |
// | Shared constants and FSM state encoding for softmax_prob_stream.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package softmax_pkg;

  localparam int N_CLASSES = 10;
  localparam int IDX_W     = 4;

  localparam logic [15:0] PROB_SAT  = 16'hFFFF;
  localparam logic [15:0] PROB_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pow2_expand.sv
// +----------------------------------------------------------------------+
// | pow2_expand                                                          |
// | Converts shared mantissa and signed base-2 exponent to Q1.15.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pow2_expand
  import softmax_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PROB_W = 16
) (
  input  logic [DATA_W-1:0] mant,
  input  logic [DATA_W-1:0] exp_val,
  output logic [PROB_W-1:0] prob
);

  localparam int SH_W = $clog2(PROB_W);

  logic              w_pos;
  logic [DATA_W:0]   w_neg;
  logic [PROB_W-1:0] w_base;

  assign w_pos  = !exp_val[DATA_W-1] && (exp_val != '0);
  // One extra bit so that -(-128) = 128 stays representable.
  assign w_neg  = -{exp_val[DATA_W-1], exp_val};
  assign w_base = {1'b1, mant, {(PROB_W-1-DATA_W){1'b0}}};

  always_comb begin
    prob = PROB_W'(PROB_ZERO);
    if (w_pos) begin
      prob = PROB_W'(PROB_SAT);
    end else if (w_neg < (DATA_W+1)'(PROB_W)) begin
      prob = w_base >> w_neg[SH_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/softmax_prob_stream.sv
// +----------------------------------------------------------------------+
// | softmax_prob_stream                                                  |
// | Captures one pseudo-softmax vector, streams ten Q1.15 probabilities  |
// | over valid/ready and reports the winning class.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module softmax_prob_stream
  import softmax_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PROB_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mant_in,
  input  logic [DATA_W-1:0] exp_in1,
  input  logic [DATA_W-1:0] exp_in2,
  input  logic [DATA_W-1:0] exp_in3,
  input  logic [DATA_W-1:0] exp_in4,
  input  logic [DATA_W-1:0] exp_in5,
  input  logic [DATA_W-1:0] exp_in6,
  input  logic [DATA_W-1:0] exp_in7,
  input  logic [DATA_W-1:0] exp_in8,
  input  logic [DATA_W-1:0] exp_in9,
  input  logic [DATA_W-1:0] exp_in10,
  output logic              prob_valid,
  input  logic              prob_ready,
  output logic [PROB_W-1:0] prob_data,
  output logic [IDX_W-1:0]  prob_idx,
  output logic              prob_last,
  output logic              argmax_valid,
  output logic [IDX_W-1:0]  argmax_idx
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DATA_W-1:0]        r_mant;
  logic [DATA_W-1:0]        r_exp [N_CLASSES];
  logic [DATA_W-1:0]        w_exp_in [N_CLASSES];
  logic signed [DATA_W-1:0] r_best_exp;
  logic [IDX_W-1:0]         r_best;
  logic [IDX_W-1:0]         r_prob_idx;
  logic [IDX_W-1:0]         r_argmax_idx;
  logic [IDX_W-1:0]         w_next_idx;
  logic [PROB_W-1:0]        r_prob_data;
  logic [PROB_W-1:0]        w_prob;
  logic                     r_prob_last;
  logic [DATA_W-1:0]        w_sel_exp;
  logic [DATA_W-1:0]        w_sel_mant;
  logic                     w_xfer;

  assign w_exp_in[0] = exp_in1;
  assign w_exp_in[1] = exp_in2;
  assign w_exp_in[2] = exp_in3;
  assign w_exp_in[3] = exp_in4;
  assign w_exp_in[4] = exp_in5;
  assign w_exp_in[5] = exp_in6;
  assign w_exp_in[6] = exp_in7;
  assign w_exp_in[7] = exp_in8;
  assign w_exp_in[8] = exp_in9;
  assign w_exp_in[9] = exp_in10;

  assign in_ready     = (r_state == IDLE);
  assign prob_valid   = (r_state == STREAM);
  assign argmax_valid = (r_state == DONE);
  assign prob_data    = r_prob_data;
  assign prob_idx     = r_prob_idx;
  assign prob_last    = r_prob_last;
  assign argmax_idx   = r_argmax_idx;
  assign w_xfer       = prob_valid && prob_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = STREAM;
      STREAM:  if (w_xfer && r_prob_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Element being loaded: class 1 straight from the inputs on capture,
  // otherwise the registered exponent for the class after the current one.
  assign w_next_idx = (r_state == IDLE) ? IDX_W'(1) : r_prob_idx + IDX_W'(1);

  always_comb begin
    w_sel_exp  = exp_in1;
    w_sel_mant = mant_in;
    if (r_state != IDLE) begin
      w_sel_mant = r_mant;
      for (int i = 0; i < N_CLASSES; i++) begin
        if (w_next_idx == IDX_W'(i + 1)) w_sel_exp = r_exp[i];
      end
    end
  end

  pow2_expand #(
    .DATA_W (DATA_W),
    .PROB_W (PROB_W)
  ) u_pow2_expand (
    .mant    (w_sel_mant),
    .exp_val (w_sel_exp),
    .prob    (w_prob)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant       <= '0;
      for (int i = 0; i < N_CLASSES; i++) r_exp[i] <= '0;
      r_best       <= '0;
      r_best_exp   <= '0;
      r_prob_data  <= '0;
      r_prob_idx   <= '0;
      r_prob_last  <= 1'b0;
      r_argmax_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mant <= mant_in;
            for (int i = 0; i < N_CLASSES; i++) r_exp[i] <= w_exp_in[i];
            r_prob_data <= w_prob;
            r_prob_idx  <= IDX_W'(1);
            r_prob_last <= 1'b0;
            r_best      <= IDX_W'(1);
            r_best_exp  <= exp_in1;
          end
        end
        STREAM: begin
          if (w_xfer) begin
            if (r_prob_last) begin
              r_argmax_idx <= r_best;
            end else begin
              r_prob_data <= w_prob;
              r_prob_idx  <= w_next_idx;
              r_prob_last <= (w_next_idx == IDX_W'(N_CLASSES));
              // Strictly greater only, so ties keep the lower class.
              if ($signed(w_sel_exp) > r_best_exp) begin
                r_best     <= w_next_idx;
                r_best_exp <= w_sel_exp;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_softmax_prob_stream.sv
// +----------------------------------------------------------------------+
// | tb_softmax_prob_stream                                               |
// | Self-checking bench: behavioural model plus directed vectors.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_softmax_prob_stream;

  localparam logic [9:0][7:0] VEC_A = {8'hF8, 8'hFC, 8'hFE, 8'h02, 8'h80,
                                       8'hF1, 8'hF0, 8'hFD, 8'hFF, 8'h00};
  localparam logic [9:0][7:0] VEC_T = {8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFE,
                                       8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFE};
  localparam logic [9:0][15:0] PROB_A = {16'h00C0, 16'h0C00, 16'h3000, 16'hFFFF, 16'h0000,
                                         16'h0001, 16'h0000, 16'h1800, 16'h6000, 16'hC000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        prob_ready = 1'b1;
  logic [7:0]  mant_v = 8'h00;
  logic [7:0]  ev [10];
  logic        in_ready, prob_valid, prob_last, argmax_valid;
  logic [15:0] prob_data;
  logic [3:0]  prob_idx, argmax_idx;

  int n_err = 0;
  int n_chk = 0;

  softmax_prob_stream #(.DATA_W(8), .PROB_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mant_in(mant_v),
    .exp_in1(ev[0]), .exp_in2(ev[1]), .exp_in3(ev[2]), .exp_in4(ev[3]), .exp_in5(ev[4]),
    .exp_in6(ev[5]), .exp_in7(ev[6]), .exp_in8(ev[7]), .exp_in9(ev[8]), .exp_in10(ev[9]),
    .prob_valid(prob_valid), .prob_ready(prob_ready), .prob_data(prob_data),
    .prob_idx(prob_idx), .prob_last(prob_last),
    .argmax_valid(argmax_valid), .argmax_idx(argmax_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: probability and winner straight from the rules.
  function automatic logic [15:0] expand(input logic [7:0] m, input logic [7:0] e);
    int s;
    int k;
    longint v;
    s = $signed(e);
    if (s > 0) return 16'hFFFF;
    k = -s;
    if (k >= 16) return 16'h0000;
    v = 32768 + 128 * int'(m);
    return 16'(v >> k);
  endfunction

  logic [7:0] mm;
  logic [7:0] me [10];
  int m_pend = 0;   // 0 idle, 1..10 element on the bus, 11 winner pulse
  int cyc = 0;

  function automatic int model_argmax();
    int best = 1;
    for (int k = 2; k <= 10; k++)
      if ($signed(me[k-1]) > $signed(me[best-1])) best = k;
    return best;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 0;
    end else begin
      cyc++;
      if (m_pend == 0) begin
        if (in_valid) begin
          mm = mant_v;
          for (int i = 0; i < 10; i++) me[i] = ev[i];
          m_pend = 1;
        end
      end else if (m_pend <= 10) begin
        if (prob_ready) m_pend++;
      end else begin
        m_pend = 0;
      end
    end
  end

  logic [15:0] got_data [$];
  int          got_idx  [$];
  int          got_cyc  [$];
  int          got_arg  [$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, m_pend == 0);
      chk("prob_valid", prob_valid, m_pend >= 1 && m_pend <= 10);
      chk("argmax_valid", argmax_valid, m_pend == 11);
      if (m_pend >= 1 && m_pend <= 10) begin
        chk("prob_data", prob_data, expand(mm, me[m_pend-1]));
        chk("prob_idx", prob_idx, m_pend);
        chk("prob_last", prob_last, m_pend == 10);
      end
      if (m_pend == 11) chk("argmax_idx", argmax_idx, model_argmax());
      if (prob_valid && prob_ready) begin
        got_data.push_back(prob_data);
        got_idx.push_back(int'(prob_idx));
        got_cyc.push_back(cyc);
      end
      if (argmax_valid) got_arg.push_back(int'(argmax_idx));
    end
  end

  logic bp_mode = 1'b0;
  int   bp_ph = 0;
  always @(posedge clk) begin
    #2;
    if (bp_mode) begin
      prob_ready = (bp_ph == 0);
      bp_ph = (bp_ph + 1) % 3;
    end
  end

  task automatic set_vec(input logic [7:0] m, input logic [9:0][7:0] e);
    mant_v = m;
    for (int i = 0; i < 10; i++) ev[i] = e[i];
  endtask

  task automatic send(input logic [7:0] m, input logic [9:0][7:0] e);
    @(posedge clk); #2;
    set_vec(m, e);
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (m_pend != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk({name, "_timeout"}, m_pend == 0, 1'b1);
  endtask

  task automatic clear_log();
    got_data.delete(); got_idx.delete(); got_cyc.delete(); got_arg.delete();
  endtask

  task automatic check_ten(input string name, input int arg_exp);
    chk({name, "_count"}, got_data.size(), 10);
    for (int i = 0; i < got_idx.size() && i < 10; i++) chk({name, "_order"}, got_idx[i], i + 1);
    chk({name, "_argcount"}, got_arg.size(), 1);
    if (got_arg.size() > 0) chk({name, "_argmax"}, got_arg[0], arg_exp);
  endtask

  initial begin
    logic [9:0][15:0] pa;
    int n;
    pa = PROB_A;
    for (int i = 0; i < 10; i++) ev[i] = 8'h00;

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_prob_valid", prob_valid, 1'b0);
    chk("rst_prob_data", prob_data, 16'h0000);
    chk("rst_prob_idx", prob_idx, 4'd0);
    chk("rst_prob_last", prob_last, 1'b0);
    chk("rst_argmax_valid", argmax_valid, 1'b0);
    chk("rst_argmax_idx", argmax_idx, 4'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Basic expansion with literal expectations
    clear_log();
    send(8'h80, VEC_A);
    wait_idle("basic", 40);
    check_ten("basic", 7);
    for (int i = 0; i < got_data.size() && i < 10; i++) chk("basic_lit", got_data[i], pa[i]);
    if (got_cyc.size() == 10) chk("basic_b2b", got_cyc[9] - got_cyc[0], 9);

    // Backpressure 1,0,0 pattern
    clear_log();
    bp_mode = 1'b1;
    send(8'h80, VEC_A);
    wait_idle("bp", 100);
    bp_mode = 1'b0;
    prob_ready = 1'b1;
    check_ten("bp", 7);
    if (got_cyc.size() == 10) chk("bp_stalled", got_cyc[9] - got_cyc[0] > 9, 1'b1);
    for (int i = 0; i < got_data.size() && i < 10; i++) chk("bp_lit", got_data[i], pa[i]);

    // Tie-break keeps lower index
    clear_log();
    send(8'h00, VEC_T);
    wait_idle("tie", 40);
    check_ten("tie", 4);
    if (got_data.size() == 10) begin
      chk("tie_lit1", got_data[0], 16'h2000);
      chk("tie_lit4", got_data[3], 16'h4000);
    end

    // Input blocking: second vector held on the input throughout
    clear_log();
    @(posedge clk); #2;
    set_vec(8'h80, VEC_A);
    in_valid = 1'b1;
    @(posedge clk); #2;
    set_vec(8'h00, VEC_T);
    n = 0;
    while (!(got_arg.size() == 1 && m_pend == 1) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk("block_timeout", n < 60, 1'b1);
    in_valid = 1'b0;
    wait_idle("block", 40);
    chk("block_count", got_data.size(), 20);
    chk("block_args", got_arg.size(), 2);
    if (got_arg.size() == 2) begin
      chk("block_arg_a", got_arg[0], 7);
      chk("block_arg_b", got_arg[1], 4);
    end
    if (got_data.size() == 20) begin
      chk("block_b_first", got_data[10], 16'h2000);
      chk("block_b_idx", got_idx[10], 1);
      chk("block_gap", got_cyc[10] - got_cyc[9], 3);
    end

    // Reset after the idx-3 transfer
    clear_log();
    send(8'h80, VEC_A);
    n = 0;
    while (got_data.size() < 3 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("rst_mid_timeout", n < 40, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_prob_valid", prob_valid, 1'b0);
    chk("rst_mid_prob_data", prob_data, 16'h0000);
    chk("rst_mid_prob_idx", prob_idx, 4'd0);
    chk("rst_mid_prob_last", prob_last, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_argmax_idx", argmax_idx, 4'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_mid_no_pulse", got_arg.size(), 0);
    clear_log();
    send(8'h80, VEC_A);
    wait_idle("after_rst", 40);
    check_ten("after_rst", 7);
    for (int i = 0; i < got_data.size() && i < 10; i++) chk("after_rst_lit", got_data[i], pa[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
